// File: rtl/mux_regbank_sequencer.sv
// mux_regbank_sequencer
//   Source stage for the 16-bit 8:1 datapath mux. Holds eight operand
//   registers feeding the mux inputs in1..in8 and scans the mux selects
//   through channels 0..7. Each channel is held for DWELL cycles.
//
//   State table
//   state | meaning
//   IDLE  | waiting for start; valid/busy low, chan parked
//   SCAN  | stepping chan 0..7, DWELL cycles each; wraps when cont=1
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   wr_en, wr_addr,  operand bank write port (addr 0 -> in1 ... 7 -> in8)
//   wr_data
//   start            begin a scan pass (only honoured in IDLE)
//   cont             continuous mode, sampled at the end of channel 7
//   in1..in8         registered operand words to the mux
//   s0, s1, s2       mux selects: s2=chan[2], s0=chan[1], s1=chan[0]
//   chan             current channel index
//   valid            selects stable, mux output meaningful
//   busy             high in SCAN
//   done             one-cycle pulse at the end of each pass
module mux_regbank_sequencer #(
   parameter int WIDTH = 16,
   parameter int DWELL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [2:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   input  logic             cont,
   output logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] in3,
   output logic [WIDTH-1:0] in4,
   output logic [WIDTH-1:0] in5,
   output logic [WIDTH-1:0] in6,
   output logic [WIDTH-1:0] in7,
   output logic [WIDTH-1:0] in8,
   output logic             s0,
   output logic             s1,
   output logic             s2,
   output logic [2:0]       chan,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

   state_t           state;
   logic [7:0]       dwell_cnt;
   logic [WIDTH-1:0] bank [8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) bank[i] <= '0;
      end else if (wr_en) begin
         bank[wr_addr] <= wr_data;
      end
   end

   assign in1 = bank[0];
   assign in2 = bank[1];
   assign in3 = bank[2];
   assign in4 = bank[3];
   assign in5 = bank[4];
   assign in6 = bank[5];
   assign in7 = bank[6];
   assign in8 = bank[7];

   // Selects are plain rewires of the chan flops, so they stay glitch-free
   // register outputs. s0/s1 are swapped relative to chan bit order.
   assign s2 = chan[2];
   assign s0 = chan[1];
   assign s1 = chan[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         chan      <= 3'd0;
         dwell_cnt <= 8'd0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= SCAN;
                  chan      <= 3'd0;
                  dwell_cnt <= 8'd0;
                  busy      <= 1'b1;
                  valid     <= 1'b1;
               end
            end
            SCAN: begin
               if (dwell_cnt == DWELL_LAST) begin
                  dwell_cnt <= 8'd0;
                  if (chan == 3'd7) begin
                     done <= 1'b1;
                     chan <= 3'd0;
                     if (!cont) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        valid <= 1'b0;
                     end
                  end else begin
                     chan <= chan + 3'd1;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
